// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The master issues operands and start; the slave returns status and result.
interface serial_subtractor_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic         b_out;

  modport master (
    output start, a, b, b_in,
    input  busy, done, d, b_out
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, d, b_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: d = (a - b - b_in) mod 2^N, one bit per clock, LSB first.
// One full-adder cell computes a + ~b + ~borrow; its carry out is the inverted borrow.
module serial_subtractor #(
  parameter int unsigned N = 4
) (
  input logic                 clk,
  input logic                 reset,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastBit = CW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  res_q;
  logic [N-1:0]  d_q;
  logic [CW-1:0] cnt_q;
  logic          borrow_q;
  logic          b_out_q;
  logic          busy_q;
  logic          done_q;

  logic          sum_bit;
  logic          carry_bit;
  logic          borrow_d;
  logic [N-1:0]  res_d;

  // Full-adder cell fed with a, ~b, ~borrow
  always_comb begin
    sum_bit   = a_q[0] ^ ~b_q[0] ^ ~borrow_q;
    carry_bit = (a_q[0] & ~b_q[0]) | (a_q[0] & ~borrow_q) | (~b_q[0] & ~borrow_q);
    borrow_d  = ~carry_bit;
    res_d     = res_q >> 1;
    res_d[N-1] = sum_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      b_out_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            borrow_q <= bus.b_in;
            res_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          borrow_q <= borrow_d;
          res_q    <= res_d;
          if (cnt_q == LastBit) begin
            // Counter parks at zero so N=1 never wraps
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            d_q     <= res_d;
            b_out_q <= borrow_d;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.d     = d_q;
  assign bus.b_out = b_out_q;

endmodule
